// File: rtl/button_event_pkg.sv
// Shared types for the button event classifier.
// State encoding and the registered event bundle.
package button_event_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    LONG = 2'd2
  } state_t;

  typedef struct packed {
    logic press;
    logic release_evt;
    logic short_press;
    logic long_press;
    logic repeat_evt;
  } evt_t;

  localparam evt_t EVT_NONE = '0;

  function automatic logic is_active(state_t s);
    return s != IDLE;
  endfunction

endpackage

// File: rtl/edge_detect.sv
// Registers din and qualifies rise/fall edges.
// Edges are masked until one clock after reset.
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic din_q;
  logic armed;

  // Previous level plus an arm flag set by the first post-reset edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      din_q <= 1'b0;
      armed <= 1'b0;
    end else begin
      din_q <= din;
      armed <= 1'b1;
    end
  end

  assign rise = armed & din & ~din_q;
  assign fall = armed & ~din & din_q;

endmodule

// File: rtl/button_event.sv
// Press / release / short / long / auto-repeat classifier.
// release and repeat are SV keywords, hence the _evt names.
module button_event
  import button_event_pkg::*;
#(
  parameter int LONG_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000,
  parameter int REPEAT_EN     = 1,
  parameter int CNT_W         = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic press,
  output logic release_evt,
  output logic short_press,
  output logic long_press,
  output logic repeat_evt,
  output logic held
);

  localparam logic [CNT_W-1:0] LONG_TC =
    CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_TC =
    CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE =
    CNT_W'(1);

  logic rise;
  logic fall;

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  evt_t             evt_n;
  logic             held_n;

  edge_detect u_edge (
    .clk  (clk),
    .rst  (rst),
    .din  (din),
    .rise (rise),
    .fall (fall)
  );

  // Next state, hold counter and next-cycle event pulses
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    evt_n   = EVT_NONE;
    unique case (state)
      IDLE: begin
        if (rise) begin
          state_n     = HELD;
          cnt_n       = '0;
          evt_n.press = 1'b1;
        end
      end
      HELD: begin
        if (fall) begin
          state_n           = IDLE;
          cnt_n             = '0;
          evt_n.short_press = 1'b1;
          evt_n.release_evt = 1'b1;
        end else if (din) begin
          if (cnt == LONG_TC) begin
            state_n          = LONG;
            cnt_n            = '0;
            evt_n.long_press = 1'b1;
          end else begin
            cnt_n = cnt + CNT_ONE;
          end
        end
      end
      LONG: begin
        if (fall) begin
          state_n           = IDLE;
          cnt_n             = '0;
          evt_n.release_evt = 1'b1;
        end else if (din) begin
          if (REPEAT_EN == 0) begin
            cnt_n = '0;
          end else if (cnt == REPEAT_TC) begin
            cnt_n            = '0;
            evt_n.repeat_evt = 1'b1;
          end else begin
            cnt_n = cnt + CNT_ONE;
          end
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
    held_n = is_active(state_n);
  end

  // State, counter and all outputs are registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      press       <= 1'b0;
      release_evt <= 1'b0;
      short_press <= 1'b0;
      long_press  <= 1'b0;
      repeat_evt  <= 1'b0;
      held        <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      press       <= evt_n.press;
      release_evt <= evt_n.release_evt;
      short_press <= evt_n.short_press;
      long_press  <= evt_n.long_press;
      repeat_evt  <= evt_n.repeat_evt;
      held        <= held_n;
    end
  end

endmodule

// File: tb/tb_button_event.sv
// Directed bench for button_event.
// Outputs packed as {press,release,short,long,repeat,held}.
module tb_button_event;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din = 1'b0;

  logic p1, r1, s1, l1, t1, h1;
  logic p2, r2, s2, l2, t2, h2;

  wire [5:0] out1 = {p1, r1, s1, l1, t1, h1};
  wire [5:0] out2 = {p2, r2, s2, l2, t2, h2};

  always #5 clk = ~clk;

  button_event #(
    .LONG_CYCLES   (8),
    .REPEAT_CYCLES (4),
    .REPEAT_EN     (1),
    .CNT_W         (4)
  ) dut1 (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .press       (p1),
    .release_evt (r1),
    .short_press (s1),
    .long_press  (l1),
    .repeat_evt  (t1),
    .held        (h1)
  );

  button_event #(
    .LONG_CYCLES   (8),
    .REPEAT_CYCLES (4),
    .REPEAT_EN     (0),
    .CNT_W         (4)
  ) dut2 (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .press       (p2),
    .release_evt (r2),
    .short_press (s2),
    .long_press  (l2),
    .repeat_evt  (t2),
    .held        (h2)
  );

  typedef struct {
    logic       din;
    logic [5:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  localparam logic [5:0] NONE = 6'b000000;
  localparam logic [5:0] PRS  = 6'b100001;
  localparam logic [5:0] HLD  = 6'b000001;
  localparam logic [5:0] SREL = 6'b011000;
  localparam logic [5:0] LNG  = 6'b000101;
  localparam logic [5:0] RPT  = 6'b000011;
  localparam logic [5:0] REL  = 6'b010000;

  task automatic check(string name, logic [7:0] act,
                       logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (%b) expected %0d (%b)",
               name, act, act, exp, exp);
    end
  endtask

  task automatic step(logic v);
    @(negedge clk);
    din = v;
    @(posedge clk);
    #1;
  endtask

  task automatic add(logic d, logic [5:0] e);
    vec_t v;
    v.din = d;
    v.exp = e;
    tbl.push_back(v);
  endtask

  task automatic add_hold_to(int last);
    add(1'b1, PRS);
    for (int k = 1; k <= last; k++) begin
      if (k == 8)
        add(1'b1, LNG);
      else if (k > 8 && (k - 8) % 4 == 0)
        add(1'b1, RPT);
      else
        add(1'b1, HLD);
    end
  endtask

  int nl1, nt1, nr1, ns1, nl2, nt2;

  initial begin
    rst = 1'b1;
    din = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_dut1", {2'b0, out1}, {2'b0, NONE});
    check("reset_dut2", {2'b0, out2}, {2'b0, NONE});
    @(negedge clk);
    rst = 1'b0;

    // short press: 3 cycles held
    add(1'b0, NONE);
    add(1'b1, PRS);
    add(1'b1, HLD);
    add(1'b1, HLD);
    add(1'b0, SREL);
    add(1'b0, NONE);
    // long hold with three repeats, release only
    add_hold_to(20);
    add(1'b0, REL);
    add(1'b0, NONE);
    // fall exactly at the long terminal count
    add_hold_to(7);
    add(1'b0, SREL);
    add(1'b0, NONE);
    // fall exactly at a repeat terminal count
    add_hold_to(11);
    add(1'b0, REL);
    add(1'b0, NONE);
    // one-cycle taps back to back
    add(1'b1, PRS);
    add(1'b0, SREL);
    add(1'b1, PRS);
    add(1'b0, SREL);
    add(1'b0, NONE);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].din);
      check($sformatf("vec%0d_dut1", i),
            {2'b0, out1}, {2'b0, tbl[i].exp});
      check($sformatf("vec%0d_dut2", i),
            {2'b0, out2}, {2'b0, tbl[i].exp & 6'b111101});
    end

    // button held through reset: nothing reported
    @(negedge clk);
    rst = 1'b1;
    din = 1'b1;
    @(posedge clk);
    #1;
    check("hold_rst_in", {2'b0, out1}, {2'b0, NONE});
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(1'b1);
      check($sformatf("hold_rst_hi%0d", k),
            {2'b0, out1 | out2}, {2'b0, NONE});
    end
    for (int k = 0; k < 2; k++) begin
      step(1'b0);
      check($sformatf("hold_rst_lo%0d", k),
            {2'b0, out1 | out2}, {2'b0, NONE});
    end

    // async reset pulse in the middle of LONG
    step(1'b1);
    check("mid_press", {2'b0, out1}, {2'b0, PRS});
    for (int k = 1; k < 10; k++) step(1'b1);
    check("mid_long_held", {7'b0, h1}, 8'd1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_async_dut1", {2'b0, out1}, {2'b0, NONE});
    check("mid_async_dut2", {2'b0, out2}, {2'b0, NONE});
    #1;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step(1'b1);
      check($sformatf("post_rst_hi%0d", k),
            {2'b0, out1 | out2}, {2'b0, NONE});
    end
    for (int k = 0; k < 2; k++) begin
      step(1'b0);
      check($sformatf("post_rst_lo%0d", k),
            {2'b0, out1 | out2}, {2'b0, NONE});
    end
    step(1'b1);
    check("new_press", {2'b0, out1}, {2'b0, PRS});
    step(1'b0);
    check("new_release", {2'b0, out1}, {2'b0, SREL});
    step(1'b0);

    // pulse counts over a 21-cycle hold, both variants
    nl1 = 0; nt1 = 0; nr1 = 0; ns1 = 0;
    nl2 = 0; nt2 = 0;
    for (int k = 0; k < 23; k++) begin
      step(k < 21);
      nl1 += int'(l1);
      nt1 += int'(t1);
      nr1 += int'(r1);
      ns1 += int'(s1);
      nl2 += int'(l2);
      nt2 += int'(t2);
    end
    check("cnt_long_dut1", 8'(nl1), 8'd1);
    check("cnt_repeat_dut1", 8'(nt1), 8'd3);
    check("cnt_release_dut1", 8'(nr1), 8'd1);
    check("cnt_short_dut1", 8'(ns1), 8'd0);
    check("cnt_long_dut2", 8'(nl2), 8'd1);
    check("cnt_repeat_dut2", 8'(nt2), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
